// File: rtl/alu_issue_ctrl_if.sv
// Instruction-issue handshake between an instruction source and alu_issue_ctrl.
interface alu_issue_ctrl_if;
  logic       instr_valid;
  logic       instr_ready;
  logic [3:0] instr_op;
  logic [1:0] instr_dst;
  logic [1:0] instr_srca;
  logic [1:0] instr_srcb;
  logic [7:0] instr_imm;

  modport master (
    output instr_valid, instr_op, instr_dst, instr_srca, instr_srcb, instr_imm,
    input  instr_ready
  );

  modport slave (
    input  instr_valid, instr_op, instr_dst, instr_srca, instr_srcb, instr_imm,
    output instr_ready
  );
endinterface

// File: rtl/alu_issue_ctrl.sv
// Single-issue controller: reads a 4x8 register file, drives an external ALU,
// writes back its result (or a load-immediate) and counts retirements.
module alu_issue_ctrl (
  input  logic             clk,
  input  logic             rst_n,
  alu_issue_ctrl_if.slave  instr,
  output logic [7:0]       alu_a,
  output logic [7:0]       alu_b,
  output logic [3:0]       alu_op,
  output logic             alu_trigger,
  input  logic [7:0]       alu_y,
  input  logic [1:0]       rd_sel,
  output logic [7:0]       rd_data,
  output logic             busy,
  output logic             done,
  output logic [7:0]       retire_cnt
);

  localparam logic [3:0] OP_LOADI = 4'b1101;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    FIRE,
    WB,
    LOAD
  } state_t;

  state_t     state, state_nxt;
  logic [7:0] regs [4];
  logic [1:0] dst_q;
  logic [7:0] imm_q;
  logic       accept;
  logic       is_loadi;
  logic       wr_en;
  logic [7:0] wr_data;

  assign instr.instr_ready = (state == IDLE);
  assign busy              = (state != IDLE);
  assign accept            = instr.instr_valid & (state == IDLE);
  assign is_loadi          = (instr.instr_op == OP_LOADI);
  assign wr_en             = (state == WB) | (state == LOAD);
  assign wr_data           = (state == WB) ? alu_y : imm_q;
  assign rd_data           = regs[rd_sel];

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (accept) state_nxt = is_loadi ? LOAD : ISSUE;
      ISSUE:   state_nxt = FIRE;
      FIRE:    state_nxt = WB;
      WB:      state_nxt = IDLE;
      LOAD:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Trigger is registered from the next state so it is high exactly in FIRE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      alu_trigger <= 1'b0;
      done        <= 1'b0;
      retire_cnt  <= '0;
    end else begin
      state       <= state_nxt;
      alu_trigger <= (state_nxt == FIRE);
      done        <= wr_en;
      if (wr_en) retire_cnt <= retire_cnt + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_a  <= '0;
      alu_b  <= '0;
      alu_op <= '0;
      dst_q  <= '0;
      imm_q  <= '0;
    end else if (accept) begin
      dst_q <= instr.instr_dst;
      if (is_loadi) begin
        imm_q <= instr.instr_imm;
      end else begin
        alu_a  <= regs[instr.instr_srca];
        alu_b  <= regs[instr.instr_srcb];
        alu_op <= instr.instr_op;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < 4; i++) regs[i] <= '0;
    end else if (wr_en) begin
      regs[dst_q] <= wr_data;
    end
  end

endmodule

// File: doc/alu_issue_ctrl.md
ALU_ISSUE_CTRL -- requirements
Module: alu_issue_ctrl

Interface
REQ-001 SHALL have ports: clk  in  1  single clock; all state rising-edge.
REQ-002 SHALL have: rst_n  in  1  reset, asynchronous, active-low.
REQ-003 SHALL have: instr_valid  in  1  instruction offered; instr_ready  out  1  controller can accept.
REQ-004 SHALL have: instr_op  in  4  ALU opcode; instr_dst, instr_srca, instr_srcb  in  2 each  register indices; instr_imm  in  8  load-immediate value.
REQ-005 SHALL have: alu_a, alu_b  out  8  ALU operands; alu_op  out  4  ALU opcode; alu_trigger  out  1  ALU capture strobe; alu_y  in  8  ALU result.
REQ-006 SHALL have: rd_sel  in  2  debug read index; rd_data  out  8  regfile[rd_sel], combinational.
REQ-007 SHALL have: busy  out  1  state != IDLE; done  out  1  one-cycle retire pulse; retire_cnt  out  8  retired-instruction count.

Function
REQ-008 SHALL hold a 4 x 8-bit register file R0..R3.
REQ-009 SHALL implement FSM states IDLE, ISSUE, FIRE, WB, LOAD.
REQ-010 instr_ready SHALL be 1 only in IDLE; accept = instr_valid & instr_ready at a clk edge.
REQ-011 On accept with instr_op != 4'b1101: latch alu_a<=R[srca], alu_b<=R[srcb], alu_op<=instr_op, dst; go to ISSUE.
REQ-012 On accept with instr_op == 4'b1101 (LOADI): latch imm and dst, go to LOAD; alu_a/alu_b/alu_op/alu_trigger unchanged.
REQ-013 ISSUE -> FIRE unconditionally; alu_trigger SHALL be a registered output, 1 exactly during FIRE, 0 otherwise.
REQ-014 FIRE -> WB unconditionally; at the edge ending WB, R[dst]<=alu_y; WB -> IDLE.
REQ-015 LOAD -> IDLE; at the edge ending LOAD, R[dst]<=imm.
REQ-016 ALU instruction latency: accept edge + 3 cycles (ISSUE, FIRE, WB); write on 3rd edge after accept; instr_ready high again the cycle after WB.
REQ-017 LOADI latency: write on 1st edge after accept.
REQ-018 done SHALL be registered, high for the one cycle following each regfile write, then low.
REQ-019 retire_cnt SHALL increment by 1 on each regfile write; 8'hFF wraps to 8'h00.
REQ-020 Opcodes 4'b1110/4'b1111 SHALL issue normally and write alu_y (ALU returns 8'h00).
REQ-021 srca/srcb/dst may coincide; operands SHALL be the values before this instruction's write.
REQ-022 rd_data SHALL show the old value during the write cycle and the new value after the write edge.
REQ-023 instr_* inputs SHALL be ignored outside the accept edge; instr_valid held high while busy SHALL not cause a second accept until IDLE.

Reset
REQ-024 rst_n=0 SHALL immediately force: state IDLE, R0..R3=0, alu_a=alu_b=0, alu_op=0, alu_trigger=0, done=0, retire_cnt=0; thus instr_ready=1, busy=0.
REQ-025 Reset asserted in ISSUE, FIRE, WB or LOAD SHALL abort with no regfile write, no done, no count increment; alu_trigger SHALL drop asynchronously.
REQ-026 After rst_n deasserts, first accept SHALL be possible on the first clk edge.

Verification
REQ-027 LOADI R1=8'h05, LOADI R2=8'h03, ADD(0000) dst R0 srca R1 srcb R2 -> one alu_trigger pulse in FIRE, R0=8'h08 three edges after accept, done one cycle, retire_cnt=3.
REQ-028 R1=8'h05, R2=8'h03, SUB(0001) dst R3 srca R1 srcb R2 -> alu_a=05, alu_b=03, R3=8'hFE (B-A).
REQ-029 R1=R2=8'h07, CMP(0100) dst R1 srca R1 srcb R2 -> R1=8'h00; then R1=03, R2=07 CMP -> 8'hFF; operands sampled pre-write.
REQ-030 instr_valid held high continuously with four LOADIs queued by stimulus -> exactly one accept per IDLE visit, instr_ready low while busy, no dropped/duplicated writes.
REQ-031 rst_n pulsed low during FIRE of ADD -> alu_trigger 0 immediately, dst unchanged (0), done never asserts, retire_cnt=0, instr_ready=1.
REQ-032 256 LOADIs retired -> retire_cnt wraps to 8'h00, done pulses 256 times.
